// File: rtl/spw_ulight_pkg.sv
// Shared SpaceWire ultra-light definitions: RX FIFO marker codes, reader FSM states
// and the RX entry classifier.
package spw_ulight_pkg;

    localparam logic [8:0] EOP_CODE = 9'h100;
    localparam logic [8:0] EEP_CODE = 9'h101;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        OUT
    } rd_state_e;

    typedef enum logic [1:0] {
        ENT_DATA,
        ENT_EOP,
        ENT_EEP,
        ENT_IGNORE
    } entry_kind_e;

    function automatic entry_kind_e decode_entry(input logic [8:0] entry);
        if (!entry[8])
            return ENT_DATA;
        else if (entry == EOP_CODE)
            return ENT_EOP;
        else if (entry == EEP_CODE)
            return ENT_EEP;
        else
            return ENT_IGNORE;
    endfunction

endpackage

// File: rtl/spw_ulight_rx_pkt_reader_if.sv
// Bundle of RX FIFO read port, host byte stream and packet status for the RX packet reader.
interface spw_ulight_rx_pkt_reader_if #(
    parameter int LEN_W = 16
);

    logic             enable;
    logic             f_empty_rx;
    logic [8:0]       datarx_flag;
    logic             read_rx_fifo_en;
    logic [7:0]       m_data;
    logic             m_valid;
    logic             m_ready;
    logic             m_first;
    logic             m_last;
    logic             pkt_done;
    logic [LEN_W-1:0] pkt_len;
    logic             pkt_eep;
    logic             pkt_trunc;
    logic [LEN_W-1:0] pkt_count;

    modport master (
        input  enable,
        input  f_empty_rx,
        input  datarx_flag,
        input  m_ready,
        output read_rx_fifo_en,
        output m_data,
        output m_valid,
        output m_first,
        output m_last,
        output pkt_done,
        output pkt_len,
        output pkt_eep,
        output pkt_trunc,
        output pkt_count
    );

    modport slave (
        output enable,
        output f_empty_rx,
        output datarx_flag,
        output m_ready,
        input  read_rx_fifo_en,
        input  m_data,
        input  m_valid,
        input  m_first,
        input  m_last,
        input  pkt_done,
        input  pkt_len,
        input  pkt_eep,
        input  pkt_trunc,
        input  pkt_count
    );

endinterface

// File: rtl/spw_ulight_rx_pkt_reader.sv
// Drains flag+byte entries from the SpaceWire RX FIFO, strips EOP/EEP and emits a
// first/last framed byte stream plus per-packet length/EEP/truncation status.
module spw_ulight_rx_pkt_reader
    import spw_ulight_pkg::*;
#(
    parameter int MAX_PKT_LEN = 1024,
    parameter int LEN_W       = 16
) (
    input  logic                            clock,
    input  logic                            reset,
    spw_ulight_rx_pkt_reader_if.master      bus
);

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_PKT_LEN);

    rd_state_e        state_q, state_d;
    logic             pend_vld_q, pend_vld_d;
    logic [7:0]       pend_byte_q, pend_byte_d;
    logic             pend_first_q, pend_first_d;
    logic [7:0]       out_data_q, out_data_d;
    logic             out_first_q, out_first_d;
    logic             out_last_q, out_last_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             trunc_q, trunc_d;
    logic             eep_q, eep_d;
    logic             done_q, done_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             peep_q, peep_d;
    logic             ptrunc_q, ptrunc_d;
    logic [LEN_W-1:0] count_q, count_d;

    entry_kind_e kind;
    logic        rd_go;

    assign kind  = decode_entry(bus.datarx_flag);
    assign rd_go = bus.enable & ~bus.f_empty_rx;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            pend_vld_q   <= 1'b0;
            pend_byte_q  <= '0;
            pend_first_q <= 1'b0;
            out_data_q   <= '0;
            out_first_q  <= 1'b0;
            out_last_q   <= 1'b0;
            cnt_q        <= '0;
            trunc_q      <= 1'b0;
            eep_q        <= 1'b0;
            done_q       <= 1'b0;
            len_q        <= '0;
            peep_q       <= 1'b0;
            ptrunc_q     <= 1'b0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            pend_vld_q   <= pend_vld_d;
            pend_byte_q  <= pend_byte_d;
            pend_first_q <= pend_first_d;
            out_data_q   <= out_data_d;
            out_first_q  <= out_first_d;
            out_last_q   <= out_last_d;
            cnt_q        <= cnt_d;
            trunc_q      <= trunc_d;
            eep_q        <= eep_d;
            done_q       <= done_d;
            len_q        <= len_d;
            peep_q       <= peep_d;
            ptrunc_q     <= ptrunc_d;
            count_q      <= count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pend_vld_d   = pend_vld_q;
        pend_byte_d  = pend_byte_q;
        pend_first_d = pend_first_q;
        out_data_d   = out_data_q;
        out_first_d  = out_first_q;
        out_last_d   = out_last_q;
        cnt_d        = cnt_q;
        trunc_d      = trunc_q;
        eep_d        = eep_q;
        done_d       = 1'b0;
        len_d        = len_q;
        peep_d       = peep_q;
        ptrunc_d     = ptrunc_q;
        count_d      = count_q;

        unique case (state_q)
            IDLE: begin
                if (rd_go)
                    state_d = RD;
            end
            RD: begin
                state_d = IDLE;
                unique case (kind)
                    ENT_DATA: begin
                        // Saturated packets keep the last held byte in pend so it can still close as last.
                        if (cnt_q == MAX_LEN) begin
                            trunc_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                            if (pend_vld_q) begin
                                out_data_d  = pend_byte_q;
                                out_first_d = pend_first_q;
                                out_last_d  = 1'b0;
                                state_d     = OUT;
                            end
                            pend_vld_d   = 1'b1;
                            pend_byte_d  = bus.datarx_flag[7:0];
                            pend_first_d = (cnt_q == '0);
                        end
                    end
                    ENT_EOP, ENT_EEP: begin
                        if (pend_vld_q) begin
                            out_data_d  = pend_byte_q;
                            out_first_d = pend_first_q;
                            out_last_d  = 1'b1;
                            eep_d       = (kind == ENT_EEP);
                            pend_vld_d  = 1'b0;
                            state_d     = OUT;
                        end else begin
                            done_d   = 1'b1;
                            len_d    = cnt_q;
                            peep_d   = (kind == ENT_EEP);
                            ptrunc_d = trunc_q;
                            count_d  = count_q + 1'b1;
                            cnt_d    = '0;
                            trunc_d  = 1'b0;
                            eep_d    = 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
            OUT: begin
                if (bus.m_ready) begin
                    if (out_last_q) begin
                        done_d   = 1'b1;
                        len_d    = cnt_q;
                        peep_d   = eep_q;
                        ptrunc_d = trunc_q;
                        count_d  = count_q + 1'b1;
                        cnt_d    = '0;
                        trunc_d  = 1'b0;
                        eep_d    = 1'b0;
                    end
                    state_d = rd_go ? RD : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        // Strobe is combinational from state, so it is gated by reset to keep outputs low in reset.
        bus.read_rx_fifo_en = ~reset & rd_go &
                              ((state_q == IDLE) | ((state_q == OUT) & bus.m_ready));
        bus.m_valid         = (state_q == OUT);
    end

    assign bus.m_data    = out_data_q;
    assign bus.m_first   = out_first_q;
    assign bus.m_last    = out_last_q;
    assign bus.pkt_done  = done_q;
    assign bus.pkt_len   = len_q;
    assign bus.pkt_eep   = peep_q;
    assign bus.pkt_trunc = ptrunc_q;
    assign bus.pkt_count = count_q;

endmodule

// File: doc/spw_ulight_rx_pkt_reader.md
# spw_ulight_rx_pkt_reader

Host-side reader for the SpaceWire ultra-light receive FIFO. It drains 9-bit entries (flag + byte) from the RX FIFO, strips EOP/EEP markers, and presents a valid/ready byte stream with first/last framing. It also reports per-packet length, error-end, and truncation status. It sits between the RX FIFO read port and the host/AXI-side consumer, on the same clock as the link wrapper.

## Interface
Parameters:
- MAX_PKT_LEN, 1024: maximum bytes delivered per packet. Bytes beyond this are dropped. Must be ≤ 2^LEN_W−1.
- LEN_W, 16: width of the length and packet counters.

Ports:
- clock  in  1  system clock (same as RX FIFO)
- reset  in  1  asynchronous, active-high reset
- enable  in  1  permits new FIFO reads
- f_empty_rx  in  1  RX FIFO empty
- datarx_flag  in  9  RX FIFO data; valid the cycle after read_rx_fifo_en
- read_rx_fifo_en  out  1  single-cycle FIFO read strobe
- m_data  out  8  stream byte
- m_valid  out  1  stream beat valid
- m_ready  in  1  consumer accepts beat
- m_first  out  1  beat is first byte of packet
- m_last  out  1  beat is last byte of packet
- pkt_done  out  1  one-cycle pulse at packet completion
- pkt_len  out  LEN_W  delivered byte count of completed packet
- pkt_eep  out  1  completed packet ended with EEP
- pkt_trunc  out  1  completed packet exceeded MAX_PKT_LEN
- pkt_count  out  LEN_W  completed packets, wraps at 2^LEN_W

## Operation
- Entry decode:
  - flag=0 → data byte.
  - 9'h100 → EOP.
  - 9'h101 → EEP.
  - Any other flag=1 value → ignored (no state change beyond the read).
- Lookahead register `pend` (valid, byte, first) holds one byte until the next entry shows whether it is last.
- FSM states IDLE, RD, OUT:
  - IDLE: if enable & !f_empty_rx, assert read_rx_fifo_en, → RD.
  - RD, data byte, pend empty: load pend. Set first=1 if the packet byte count is 0. → IDLE.
  - RD, data byte, pend full: output register ← pend with last=0. pend ← new byte. → OUT.
  - RD, EOP/EEP, pend full: output register ← pend with last=1. Latch the eep flag. → OUT.
  - RD, EOP/EEP, pend empty: pulse pkt_done with the current len/eep/trunc, clear the packet state, → IDLE.
  - OUT: m_valid=1. On m_ready:
    - If the beat was last: pulse pkt_done, update status, increment pkt_count, clear the packet state.
    - Then, if enable & !f_empty_rx, assert read_rx_fifo_en and → RD; else → IDLE.
- Byte counter increments when a byte enters pend. Once the count reaches MAX_PKT_LEN, further data bytes are discarded and the trunc flag is set; the count saturates.
- pkt_len, pkt_eep, pkt_trunc hold their value until the next pkt_done.
- At most one FIFO read is outstanding. read_rx_fifo_en is never asserted in RD.
- enable low: the outstanding read completes and the pending beat is still delivered; no new reads are issued.

## Timing
- Reset values: every output is 0; the FSM is in IDLE and pend is empty.
- FIFO read latency is 1 cycle: an entry is sampled in RD, one cycle after the strobe.
- m_valid rises the cycle after RD. m_data, m_first, m_last are stable while m_valid & !m_ready.
- Sustained throughput is one beat per 2 cycles with m_ready=1.
- pkt_done asserts in the cycle after the last beat handshake. For an empty packet (EOP with pend empty), it asserts the cycle after RD.
- f_empty_rx mid-packet: wait in IDLE with pend retained; there is no timeout.
- Reset mid-packet: all state is cleared. The next data byte after reset is treated as a new packet's first byte.

## Structure
- Shared package spw_ulight_pkg holds:
  - EOP_CODE = 9'h100 and EEP_CODE = 9'h101
  - the reader state enum (IDLE, RD, OUT)
- Single module. No sub-module; the lookahead and output registers are local.

## Test plan
- FIFO {0x0AA,0x0BB,0x0CC,0x100}, m_ready=1 → beats AA(first), BB, CC(last); pkt_done with len=3, eep=0, trunc=0; pkt_count=1.
- FIFO {0x011,0x101} → one beat 0x11 with first=last=1; pkt_eep=1, len=1.
- FIFO {0x100} → no beats; pkt_done pulse with len=0. Then {0x022,0x100} → 0x22 with first=last=1.
- MAX_PKT_LEN=4, FIFO 6 data bytes then 0x100 → 4 beats, 4th with last=1; len=4, trunc=1.
- m_ready held low 10 cycles on a beat → m_data stable, no read_rx_fifo_en pulses, no byte lost; 0x1FF entries mid-packet are ignored.
- reset asserted mid-packet after 2 beats → all outputs 0 asynchronously. The next packet {0x033,0x100} delivers 0x33 with m_first=1 and len=1.
